// File: rtl/rx_response_unit_pkg.sv
// Shared types and defaults for the receive-side response front end.
package rx_response_unit_pkg;

  localparam int unsigned DEF_IO_BITS        = 2;
  localparam int unsigned DEF_PAYLOAD_CYCLES = 8;
  localparam int unsigned DEF_PENDING_DEPTH  = 2;

  typedef enum logic [1:0] {
    RX_KIND_PREFETCH16 = 2'd0,
    RX_KIND_DATA16     = 2'd1,
    RX_KIND_DATA8      = 2'd2
  } rx_kind_e;

  typedef enum logic [1:0] {
    RX_STATE_IDLE    = 2'd0,
    RX_STATE_PAYLOAD = 2'd1,
    RX_STATE_GAP     = 2'd2
  } rx_state_e;

  // An 8-bit payload occupies half the cycles of a 16-bit one.
  function automatic int unsigned payload_len(input logic [1:0] kind,
                                              input int unsigned cycles);
    if (kind == RX_KIND_DATA8) begin
      return cycles / 32'd2;
    end else begin
      return cycles;
    end
  endfunction

endpackage

// File: rtl/rx_response_unit_srfifo.sv
// Shift-register FIFO: head always sits in slot 0; a pop in the same cycle
// as a push frees the slot first, so a full queue still accepts that push.
module rx_response_unit_srfifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned BITS  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            add_i,
  input  logic            remove_i,
  input  logic [BITS-1:0] data_i,
  output logic [BITS-1:0] last_entry_o,
  output logic            can_add_o,
  output logic            not_empty_o
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] wpos_s;
  logic            pop_s, push_s;

  assign pop_s        = remove_i && (count_q != {CNTW{1'b0}});
  assign can_add_o    = (count_q != CNTW'(DEPTH)) || pop_s;
  assign push_s       = add_i && can_add_o;
  assign wpos_s       = count_q - CNTW'(pop_s);
  assign last_entry_o = mem_q[0];
  assign not_empty_o  = (count_q != {CNTW{1'b0}});

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (pop_s && (i < int'(DEPTH) - 1)) begin
        mem_d[i] = mem_q[i+1];
      end else begin
        mem_d[i] = mem_q[i];
      end
      if (push_s && (wpos_s == CNTW'(i))) begin
        mem_d[i] = data_i;
      end else begin
        mem_d[i] = mem_d[i];
      end
    end
    count_d = count_q + CNTW'(push_s) - CNTW'(pop_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CNTW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {BITS{1'b0}};
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/rx_response_unit.sv
// Receive front end: matches incoming responses to the kinds of issued reads,
// detects the start symbol, frames the payload and steers its strobes.
module rx_response_unit
  import rx_response_unit_pkg::*;
#(
  parameter int unsigned IO_BITS        = DEF_IO_BITS,
  parameter int unsigned PAYLOAD_CYCLES = DEF_PAYLOAD_CYCLES,
  parameter int unsigned PENDING_DEPTH  = DEF_PENDING_DEPTH,
  localparam int unsigned CW            = $clog2(PAYLOAD_CYCLES) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_command_started_i,
  input  logic [1:0]         tx_kind_i,
  output logic               pending_full_o,
  output logic               any_pending_o,
  input  logic [IO_BITS-1:0] rx_pins_i,
  output logic               rx_started_o,
  output logic               rx_active_o,
  output logic [IO_BITS-1:0] rx_sbs_o,
  output logic               rx_sbs_valid_o,
  output logic               rx_data_valid_o,
  output logic               rx_exec_data_valid_o,
  output logic [CW-1:0]      rx_counter_o,
  output logic               rx_done_o,
  output logic               rx_exec_done_o,
  output logic               rx_error_o
);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    kind_q, kind_d;
  logic          err_q, err_d;

  logic          start_s, pins_nz_s, q_nonempty_s, can_add_s;
  logic [1:0]    head_kind_s;
  logic [CW-1:0] last_idx_s;
  logic          payload_s, last_s, is_pf_s;

  rx_response_unit_srfifo #(
    .DEPTH (PENDING_DEPTH),
    .BITS  (2)
  ) u_pending (
    .clk          (clk),
    .reset        (reset),
    .add_i        (tx_command_started_i),
    .remove_i     (start_s),
    .data_i       (tx_kind_i),
    .last_entry_o (head_kind_s),
    .can_add_o    (can_add_s),
    .not_empty_o  (q_nonempty_s)
  );

  assign pins_nz_s  = |rx_pins_i;
  assign last_idx_s = CW'(payload_len(kind_q, PAYLOAD_CYCLES) - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_STATE_IDLE;
      cnt_q   <= {CW{1'b0}};
      kind_q  <= RX_KIND_PREFETCH16;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    err_d   = err_q;
    case (state_q)
      RX_STATE_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (start_s) begin
          kind_d  = head_kind_s;
          state_d = RX_STATE_PAYLOAD;
        end else if (pins_nz_s) begin
          // A response nobody asked for: flag it and stay put.
          err_d = 1'b1;
        end else begin
          state_d = RX_STATE_IDLE;
        end
      end
      RX_STATE_PAYLOAD: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == last_idx_s) begin
          state_d = RX_STATE_GAP;
        end else begin
          state_d = RX_STATE_PAYLOAD;
        end
      end
      RX_STATE_GAP: begin
        cnt_d   = {CW{1'b0}};
        state_d = RX_STATE_IDLE;
      end
      default: begin
        cnt_d   = {CW{1'b0}};
        state_d = RX_STATE_IDLE;
      end
    endcase
  end

  always_comb begin
    start_s              = (state_q == RX_STATE_IDLE) && pins_nz_s && q_nonempty_s;
    payload_s            = (state_q == RX_STATE_PAYLOAD);
    last_s               = payload_s && (cnt_q == last_idx_s);
    is_pf_s              = (kind_q == RX_KIND_PREFETCH16);
    rx_started_o         = start_s;
    rx_sbs_valid_o       = start_s;
    rx_sbs_o             = start_s ? rx_pins_i : {IO_BITS{1'b0}};
    rx_active_o          = start_s || (state_q != RX_STATE_IDLE);
    rx_data_valid_o      = payload_s && is_pf_s;
    rx_exec_data_valid_o = payload_s && !is_pf_s;
    rx_done_o            = last_s && is_pf_s;
    rx_exec_done_o       = last_s && !is_pf_s;
    rx_counter_o         = cnt_q;
    rx_error_o           = err_q;
    pending_full_o       = !can_add_s;
    any_pending_o        = q_nonempty_s || (state_q != RX_STATE_IDLE);
  end

endmodule

// File: tb/tb_rx_response_unit.sv
// Self-checking bench for rx_response_unit against a queue/beat-index model.
module tb_rx_response_unit;
  import rx_response_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_command_started = 1'b0;
  logic [1:0] tx_kind = 2'b00;
  logic [1:0] rx_pins = 2'b00;
  logic       pending_full_o, any_pending_o, rx_started_o, rx_active_o;
  logic [1:0] rx_sbs_o;
  logic       rx_sbs_valid_o, rx_data_valid_o, rx_exec_data_valid_o;
  logic [3:0] rx_counter_o;
  logic       rx_done_o, rx_exec_done_o, rx_error_o;

  rx_response_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .tx_command_started_i (tx_command_started),
    .tx_kind_i            (tx_kind),
    .pending_full_o       (pending_full_o),
    .any_pending_o        (any_pending_o),
    .rx_pins_i            (rx_pins),
    .rx_started_o         (rx_started_o),
    .rx_active_o          (rx_active_o),
    .rx_sbs_o             (rx_sbs_o),
    .rx_sbs_valid_o       (rx_sbs_valid_o),
    .rx_data_valid_o      (rx_data_valid_o),
    .rx_exec_data_valid_o (rx_exec_data_valid_o),
    .rx_counter_o         (rx_counter_o),
    .rx_done_o            (rx_done_o),
    .rx_exec_done_o       (rx_exec_done_o),
    .rx_error_o           (rx_error_o)
  );

  always #5 clk = ~clk;

  logic [15:0] obs_v;
  assign obs_v = {pending_full_o, any_pending_o, rx_started_o, rx_active_o,
                  rx_sbs_o, rx_sbs_valid_o, rx_data_valid_o, rx_exec_data_valid_o,
                  rx_counter_o, rx_done_o, rx_exec_done_o, rx_error_o};

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Model: queue of pending kinds; beat = -1 idle, 0..N-1 payload, N gap.
  int   mq[$];
  int   beat = -1;
  int   mkind = 0;
  bit   merr = 1'b0;
  bit   exp_start, exp_full;
  logic [15:0] exp_v;
  bit   in_rst, in_push;
  int   in_kind;
  logic [1:0] in_pins;

  function automatic int n_of(input int k);
    return (k == 2) ? 4 : 8;
  endfunction

  task automatic drive(input bit rst, input bit push, input int k, input logic [1:0] pins);
    int n, cnt;
    bit act, pay, dv, ev, dn, edn, anyp;
    logic [3:0] cnt_v;
    @(negedge clk);
    cyc++;
    reset = rst;
    tx_command_started = push;
    tx_kind = k[1:0];
    rx_pins = pins;
    in_rst = rst; in_push = push; in_kind = k; in_pins = pins;
    #1;
    n = n_of(mkind);
    exp_start = (beat < 0) && (pins != 2'b00) && (mq.size() > 0);
    exp_full  = (mq.size() >= 2) && !exp_start;
    act  = exp_start || (beat >= 0);
    pay  = (beat >= 0) && (beat < n);
    cnt  = (beat >= 0) ? beat : 0;
    cnt_v = cnt[3:0];
    dv   = pay && (mkind == 0);
    ev   = pay && (mkind != 0);
    dn   = dv && (beat == n - 1);
    edn  = ev && (beat == n - 1);
    anyp = (mq.size() > 0) || (beat >= 0);
    exp_v = {exp_full, anyp, exp_start, act, exp_start ? pins : 2'b00, exp_start,
             dv, ev, cnt_v, dn, edn, merr};
  endtask

  task automatic advance();
    int n;
    if (in_rst) begin
      mq.delete();
      beat = -1;
      mkind = 0;
      merr = 1'b0;
    end else begin
      n = n_of(mkind);
      if (beat < 0 && in_pins != 2'b00 && mq.size() == 0) merr = 1'b1;
      if (exp_start) begin
        mkind = mq.pop_front();
        beat = 0;
      end else if (beat == n) begin
        beat = -1;
      end else if (beat >= 0) begin
        beat = beat + 1;
      end
      if (in_push && !exp_full) mq.push_back(in_kind);
    end
  endtask

  function automatic logic [1:0] rnd_pins();
    int r;
    logic [1:0] p;
    r = $urandom_range(3, 0);
    p = r[1:0];
    return p;
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b0, 0, 2'b00); advance();
    drive(1'b1, 1'b0, 0, 2'b00); advance();
    drive(1'b0, 1'b0, 0, 2'b00);
    checks++;
    if (obs_v !== 16'h0000) $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_v, 16'h0000);
    else passes++;
    advance();
  endtask

  task automatic test_prefetch();
    int c;
    drive(1'b0, 1'b1, 0, 2'b00);
    checks++;
    if (obs_v !== exp_v) $display("FAIL pf_push cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
    advance();
    drive(1'b0, 1'b0, 0, 2'b01);
    checks++;
    if (rx_sbs_o !== 2'b01 || rx_started_o !== 1'b1) $display("FAIL pf_sbs cyc=%0d got=%b/%b exp=01/1", cyc, rx_sbs_o, rx_started_o);
    else passes++;
    advance();
    for (int i = 0; i < 10; i++) begin
      c = i % 4;
      drive(1'b0, 1'b0, 0, (i < 8) ? c[1:0] : 2'b00);
      checks++;
      if (obs_v !== exp_v) $display("FAIL pf_frame cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
      advance();
    end
  endtask

  task automatic test_data8();
    bit seen_dv = 1'b0;
    drive(1'b0, 1'b1, 2, 2'b00); advance();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 0, (i == 0) ? 2'b11 : rnd_pins());
      seen_dv |= rx_data_valid_o;
      checks++;
      if (obs_v !== exp_v) $display("FAIL d8_frame cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
      advance();
    end
    checks++;
    if (seen_dv !== 1'b0) $display("FAIL d8_no_pf got=%b exp=0", seen_dv); else passes++;
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 0, 2'b00); advance();
    drive(1'b0, 1'b1, 1, 2'b00); advance();
    drive(1'b0, 1'b0, 0, 2'b00);
    checks++;
    if (pending_full_o !== 1'b1) $display("FAIL b2b_full got=%b exp=1", pending_full_o); else passes++;
    advance();
    for (int i = 0; i < 26; i++) begin
      drive(1'b0, (i == 0), 2, (beat < 0 && mq.size() > 0) ? 2'b01 : rnd_pins());
      checks++;
      if (obs_v !== exp_v) $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
      advance();
    end
  endtask

  task automatic test_error();
    drive(1'b0, 1'b0, 0, 2'b10);
    checks++;
    if (rx_started_o !== 1'b0) $display("FAIL err_nostart got=%b exp=0", rx_started_o); else passes++;
    advance();
    drive(1'b0, 1'b1, 0, 2'b00);
    checks++;
    if (rx_error_o !== 1'b1) $display("FAIL err_sticky got=%b exp=1", rx_error_o); else passes++;
    advance();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b0, 0, (i == 0) ? 2'b10 : rnd_pins());
      checks++;
      if (obs_v !== exp_v) $display("FAIL err_frame cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
      advance();
    end
  endtask

  task automatic test_gap_start();
    drive(1'b0, 1'b1, 1, 2'b00); advance();
    drive(1'b0, 1'b1, 2, 2'b00); advance();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b0, 0, (beat == n_of(mkind)) ? 2'b11 :
                           (beat < 0 && mq.size() > 0) ? 2'b01 : rnd_pins());
      checks++;
      if (obs_v !== exp_v) $display("FAIL gap_start cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 0, 2'b00); advance();
    drive(1'b0, 1'b1, 1, 2'b01); advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 0, rnd_pins()); advance();
    end
    drive(1'b1, 1'b0, 0, 2'b11);
    checks++;
    if (obs_v !== exp_v || rx_counter_o !== 4'd3) $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
    advance();
    drive(1'b0, 1'b0, 0, 2'b00);
    checks++;
    if (obs_v !== 16'h0000) $display("FAIL rst_mid_after got=%h exp=%h", obs_v, 16'h0000); else passes++;
    advance();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99, 0);
      drive((r == 0), ($urandom_range(3, 0) == 0), $urandom_range(2, 0),
            ($urandom_range(2, 0) == 0) ? rnd_pins() : 2'b00);
      checks++;
      if (obs_v !== exp_v) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); else passes++;
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_data8();
    test_back_to_back();
    test_error();
    test_gap_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
